// File: rtl/q_action_select.sv
// q_action_select: reads the 4 Q-values of a state, returns argmax and max.
// Optional epsilon-greedy exploration is enabled with macro Q_EPS_GREEDY_EN.
`default_nettype none

module q_action_select #(
   parameter int STATE_W = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [STATE_W-1:0]     req_state,
   output logic                   mem_rd_en,
   output logic [STATE_W+1:0]     mem_addr,
   input  logic signed [15:0]     mem_rd_data,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [1:0]             rsp_action,
   output logic signed [15:0]     rsp_q_max,
`ifdef Q_EPS_GREEDY_EN
   output logic                   rsp_explore,
   input  logic [15:0]            epsilon
`else
   output logic                   rsp_explore
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_LAST  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [STATE_W+1:0]   addr_q, addr_d;
   logic                 rd_pend_q, rd_pend_d;
   logic [1:0]           rd_idx_q, rd_idx_d;
   logic signed [15:0]   max_q, max_d;
   logic [1:0]           arg_q, arg_d;
   logic [1:0]           rsp_action_q, rsp_action_d;
   logic signed [15:0]   rsp_q_max_q, rsp_q_max_d;
   logic                 rsp_explore_q, rsp_explore_d;

   logic signed [15:0]   upd_max;
   logic [1:0]           upd_arg;
   logic                 explore;
   logic [1:0]           explore_action;

`ifdef Q_EPS_GREEDY_EN
   logic [15:0]          lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   end

   assign explore        = ({4'b0000, lfsr_q[11:0]} < epsilon);
   assign explore_action = lfsr_q[13:12];
`else
   assign explore        = 1'b0;
   assign explore_action = 2'd0;
`endif

   // Running argmax: action 0 seeds it, later actions win only when strictly greater.
   always_comb begin
      upd_max = max_q;
      upd_arg = arg_q;
      if (rd_pend_q) begin
         if ((rd_idx_q == 2'd0) || (mem_rd_data > max_q)) begin
            upd_max = mem_rd_data;
            upd_arg = rd_idx_q;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      addr_d        = addr_q;
      rd_pend_d     = (state_q == S_FETCH);
      rd_idx_d      = cnt_q;
      max_d         = upd_max;
      arg_d         = upd_arg;
      rsp_action_d  = rsp_action_q;
      rsp_q_max_d   = rsp_q_max_q;
      rsp_explore_d = rsp_explore_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d  = {req_state, 2'b00};
               cnt_d   = 2'd0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (cnt_q == 2'd3) begin
               state_d = S_LAST;
            end else begin
               cnt_d  = cnt_q + 2'd1;
               addr_d = {addr_q[STATE_W+1:2], cnt_q + 2'd1};
            end
         end
         S_LAST: begin
            state_d     = S_RESP;
            rsp_q_max_d = upd_max;
            if (explore) begin
               rsp_action_d  = explore_action;
               rsp_explore_d = 1'b1;
            end else begin
               rsp_action_d  = upd_arg;
               rsp_explore_d = 1'b0;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= 2'd0;
         addr_q        <= '0;
         rd_pend_q     <= 1'b0;
         rd_idx_q      <= 2'd0;
         max_q         <= 16'sd0;
         arg_q         <= 2'd0;
         rsp_action_q  <= 2'd0;
         rsp_q_max_q   <= 16'sd0;
         rsp_explore_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         rd_pend_q     <= rd_pend_d;
         rd_idx_q      <= rd_idx_d;
         max_q         <= max_d;
         arg_q         <= arg_d;
         rsp_action_q  <= rsp_action_d;
         rsp_q_max_q   <= rsp_q_max_d;
         rsp_explore_q <= rsp_explore_d;
      end
   end

`ifdef Q_EPS_GREEDY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`endif

   assign req_ready   = (state_q == S_IDLE);
   assign mem_rd_en   = (state_q == S_FETCH);
   assign mem_addr    = addr_q;
   assign rsp_valid   = (state_q == S_RESP);
   assign rsp_action  = rsp_action_q;
   assign rsp_q_max   = rsp_q_max_q;
`ifdef Q_EPS_GREEDY_EN
   assign rsp_explore = rsp_explore_q;
`else
   assign rsp_explore = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_q_action_select.sv
// Directed testbench for q_action_select with a behavioural Q-table memory.
// Define Q_EPS_GREEDY_EN to also exercise the exploration path.
`default_nettype none

module tb_q_action_select;

   localparam int STATE_W = 6;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 req_valid;
   logic                 req_ready;
   logic [STATE_W-1:0]   req_state;
   logic                 mem_rd_en;
   logic [STATE_W+1:0]   mem_addr;
   logic [15:0]          mem_rd_data;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [1:0]           rsp_action;
   logic [15:0]          rsp_q_max;
   logic                 rsp_explore;
`ifdef Q_EPS_GREEDY_EN
   logic [15:0]          epsilon;
   logic [15:0]          m_lfsr;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] qtab [0:(1<<(STATE_W+2))-1];

   q_action_select #(.STATE_W(STATE_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_state   (req_state),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_action  (rsp_action),
      .rsp_q_max   (rsp_q_max),
`ifdef Q_EPS_GREEDY_EN
      .rsp_explore (rsp_explore),
      .epsilon     (epsilon)
`else
      .rsp_explore (rsp_explore)
`endif
   );

   always #5 clk = ~clk;

   // One-cycle read latency memory
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= qtab[mem_addr];
   end

`ifdef Q_EPS_GREEDY_EN
   // Reference LFSR, right-shifting Galois form with taps mask 0xB400
   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input logic [STATE_W-1:0] s,
                          input logic [15:0] q0, input logic [15:0] q1,
                          input logic [15:0] q2, input logic [15:0] q3,
                          input logic [1:0] exp_arg, input logic [15:0] exp_max,
                          input int hold);
      logic [1:0] exp_act;
      logic       exp_x;
      qtab[{s, 2'd0}] = q0;
      qtab[{s, 2'd1}] = q1;
      qtab[{s, 2'd2}] = q2;
      qtab[{s, 2'd3}] = q3;
      exp_act = exp_arg;
      exp_x   = 1'b0;
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_state = s;
      step();
      req_valid = 1'b0;
      req_state = '0;
      for (int a = 0; a < 4; a++) begin
         chk("fetch_rd_en", mem_rd_en, 1);
         chk("fetch_addr", mem_addr, {s, a[1:0]});
         chk("fetch_no_rsp", {req_ready, rsp_valid}, 0);
         step();
      end
      chk("last_rd_en", mem_rd_en, 0);
      chk("last_addr_hold", mem_addr, {s, 2'd3});
      chk("last_no_rsp", rsp_valid, 0);
`ifdef Q_EPS_GREEDY_EN
      if ({4'b0000, m_lfsr[11:0]} < epsilon) begin
         exp_x   = 1'b1;
         exp_act = m_lfsr[13:12];
      end
`endif
      step();
      chk("rsp_valid_rise", rsp_valid, 1);
      chk("rsp_action", rsp_action, exp_act);
      chk("rsp_q_max", rsp_q_max, exp_max);
      chk("rsp_explore", rsp_explore, exp_x);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         step();
         chk("bp_valid", rsp_valid, 1);
         chk("bp_stable", {rsp_action, rsp_q_max, rsp_explore}, {exp_act, exp_max, exp_x});
         chk("bp_req_ready", req_ready, 0);
         chk("bp_rd_en", mem_rd_en, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rsp_valid_fall", rsp_valid, 0);
      chk("req_ready_back", req_ready, 1);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_state = '0;
      rsp_ready = 1'b0;
`ifdef Q_EPS_GREEDY_EN
      epsilon   = 16'h0000;
`endif
      for (int i = 0; i < (1<<(STATE_W+2)); i++) qtab[i] = 16'h0000;
      #1;
      chk("reset_req_ready", req_ready, 1);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_mem", {mem_rd_en, mem_addr}, 0);
      chk("reset_rsp", {rsp_action, rsp_q_max, rsp_explore}, 0);
      step();
      step();
      rst = 1'b0;
      step();

      // Greedy lookups: mixed signs, negative ties, full-scale, all-equal, last wins
      run_req(6'd5,  16'h0100, 16'h0800, 16'hF000, 16'h0400, 2'd1, 16'h0800, 0);
      run_req(6'd9,  16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 2'd2, 16'hFFFF, 0);
      run_req(6'd63, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 2'd0, 16'h7FFF, 0);
      run_req(6'd0,  16'h8000, 16'h8000, 16'h8000, 16'h8000, 2'd0, 16'h8000, 0);
      run_req(6'd12, 16'h0000, 16'h0001, 16'h0002, 16'h7FFF, 2'd3, 16'h7FFF, 10);

      // Abort a lookup after two reads
      req_valid = 1'b1;
      req_state = 6'd20;
      step();
      req_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      chk("abort_req_ready", req_ready, 1);
      chk("abort_mem", {mem_rd_en, mem_addr}, 0);
      chk("abort_rsp", {rsp_valid, rsp_action, rsp_q_max, rsp_explore}, 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("abort_no_rsp", rsp_valid, 0);
         chk("abort_idle", req_ready, 1);
      end
      run_req(6'd5,  16'h0100, 16'h0800, 16'hF000, 16'h0400, 2'd1, 16'h0800, 0);

`ifdef Q_EPS_GREEDY_EN
      // Full epsilon: every response explores with the LFSR-chosen action
      epsilon = 16'h1000;
      run_req(6'd33, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 2'd3, 16'h0400, 0);
      step();
      run_req(6'd34, 16'h0400, 16'h0300, 16'h0200, 16'h0100, 2'd0, 16'h0400, 2);
      epsilon = 16'h0000;
      run_req(6'd35, 16'hF000, 16'hE000, 16'hF001, 16'hF000, 2'd2, 16'hF001, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/q_action_select.md
Q_ACTION_SELECT -- requirements
Module: q_action_select

Interface
REQ-001 SHALL have parameter STATE_W, default 6, giving the state index width (2^STATE_W states, 4 actions each).
REQ-002 SHALL have port clk, input, 1 bit: clock, rising edge active.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: lookup request valid.
REQ-005 SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-006 SHALL have port req_state, input, STATE_W bits: state index to look up.
REQ-007 SHALL have port mem_rd_en, output, 1 bit: Q-table read strobe.
REQ-008 SHALL have port mem_addr, output, STATE_W+2 bits: read address {state, action}.
REQ-009 SHALL have port mem_rd_data, input, signed 16 bits, Q4.12: read data, valid exactly 1 cycle after its mem_rd_en.
REQ-010 SHALL have port rsp_valid, output, 1 bit: response valid.
REQ-011 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-012 SHALL have port rsp_action, output, 2 bits: selected action.
REQ-013 SHALL have port rsp_q_max, output, signed 16 bits, Q4.12: maximum Q over the 4 actions.
REQ-014 SHALL have port rsp_explore, output, 1 bit: rsp_action came from exploration, not argmax.

Function
REQ-015 SHALL implement the FSM IDLE -> FETCH -> LAST -> RESP -> IDLE.
REQ-016 In IDLE, req_ready SHALL be 1; req_ready SHALL be 0 in all other states.
REQ-017 A request SHALL be accepted on the edge where req_valid and req_ready are both 1; req_state SHALL be latched on that edge and the FSM SHALL enter FETCH.
REQ-018 FETCH SHALL last exactly 4 cycles, asserting mem_rd_en with mem_addr = {latched state, a} for a = 0, 1, 2, 3 in order.
REQ-019 LAST SHALL last 1 cycle, with mem_rd_en = 0, and SHALL capture the read data for action 3.
REQ-020 The running max SHALL be initialised from action 0 data; a later action SHALL replace it only if strictly greater (signed compare), so ties resolve to the lowest action index.
REQ-021 rsp_valid SHALL rise in the 6th cycle after the acceptance edge and SHALL hold, with all rsp_* outputs stable, until the edge where rsp_ready = 1.
REQ-022 On rsp_valid and rsp_ready both 1, the FSM SHALL return to IDLE and rsp_valid SHALL fall the following cycle; a new request cannot be accepted in the same cycle as the response handshake.
REQ-023 rsp_ready SHALL be ignored outside RESP, and req_valid SHALL be ignored outside IDLE.
REQ-024 Full-scale values (0x8000, 0x7FFF) SHALL compare correctly, with no overflow.
REQ-025 When mem_rd_en = 0, mem_addr SHALL hold its last value.

Reset
REQ-026 rst SHALL asynchronously force: state IDLE, req_ready = 1, rsp_valid = 0, mem_rd_en = 0, mem_addr = 0, rsp_action = 0, rsp_q_max = 0, rsp_explore = 0, LFSR = 0xACE1.
REQ-027 rst asserted mid-FETCH or mid-RESP SHALL abort the lookup with no response; after deassertion the block SHALL be in IDLE.

Configuration
REQ-028 Macro Q_EPS_GREEDY_EN SHALL gate epsilon-greedy exploration.
REQ-029 With Q_EPS_GREEDY_EN defined, the block SHALL add:
- input port epsilon, unsigned 16 bits, Q4.12, range 0..0x1000;
- a 16-bit Galois LFSR (taps mask 0xB400) that advances every cycle.
REQ-030 With Q_EPS_GREEDY_EN defined, on the LAST -> RESP transition:
- if {4'b0, lfsr[11:0]} < epsilon: rsp_action = lfsr[13:12] and rsp_explore = 1;
- otherwise: rsp_action = argmax and rsp_explore = 0;
- rsp_q_max SHALL always be the true max.
REQ-031 Without Q_EPS_GREEDY_EN, port epsilon and the LFSR SHALL be absent, rsp_action SHALL always be argmax, and rsp_explore SHALL be constant 0.

Verification
REQ-032 Greedy case: Q[5] = {0x0100, 0x0800, 0xF000, 0x0400}; request state 5 -> addresses 0x14..0x17 on 4 consecutive cycles; rsp_action = 1, rsp_q_max = 0x0800, rsp_valid rises 6 cycles after acceptance.
REQ-033 All-negative ties: Q = {0x8000, 0x8000, 0xFFFF, 0xFFFF} -> rsp_action = 2, rsp_q_max = 0xFFFF.
REQ-034 Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_* stable throughout, req_ready = 0 throughout; response completes on rsp_ready = 1.
REQ-035 Reset mid-FETCH (after 2 reads): rst pulse -> no rsp_valid; req_ready = 1 after reset; the next request completes normally.
REQ-036 With Q_EPS_GREEDY_EN: epsilon = 0 -> rsp_explore = 0 always; epsilon = 0x1000 -> rsp_explore = 1 always, and rsp_action matches the reference-model LFSR bits [13:12] from seed 0xACE1.
